// File: rtl/cond_logic_pkg.sv
// Shared constants for the condition-evaluation and flag-register logic:
// ARM condition codes, flag bit positions and flag-write group indices.
package cond_logic_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagW bit index per group; group g owns Flags[2g+1:2g].
    localparam int FLAGW_NZ    = 1;
    localparam int FLAGW_CV    = 0;
    localparam int FLAG_GROUPS = 2;

endpackage

// File: rtl/cond_logic_cond_check.sv
// Purely combinational evaluation of a 4-bit condition field against
// the architectural flags {N,Z,C,V}.
module cond_check
    import cond_logic_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds the NZCV flag register, evaluates the
// instruction condition and gates the decoder's write/branch strobes.
module cond_logic
    import cond_logic_pkg::*;
#(
    parameter int NONE_REG = 0
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       stall,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic [3:0] flags_reg;
    logic [3:0] flags_next;
    logic       eval_ex;
    logic       cond_ex;

    // Evaluation always reads the registered flags, so a flag write in this
    // cycle only becomes visible to the next instruction.
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_reg),
        .CondEx (eval_ex)
    );

    generate
        if (NONE_REG != 0) begin : g_condex_reg
            logic condex_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    condex_reg <= 1'b0;
                end else if (!stall) begin
                    condex_reg <= eval_ex;
                end
            end

            assign cond_ex = condex_reg;
        end else begin : g_condex_comb
            assign cond_ex = eval_ex;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < FLAG_GROUPS; gi++) begin : g_flag_grp
            assign flags_next[2*gi +: 2] = (FlagW[gi] & cond_ex & ~stall)
                                         ? ALUFlags[2*gi +: 2]
                                         : flags_reg[2*gi +: 2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_reg <= 4'b0000;
        end else begin
            flags_reg <= flags_next;
        end
    end

    assign PCSrc    = PCS & cond_ex;
    assign RegWrite = RegW & cond_ex & ~NoWrite;
    assign MemWrite = MemW & cond_ex;
    assign CondEx   = cond_ex;
    assign Flags    = flags_reg;

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 Parameter: NONE_REG, default 0; 1 = CondEx output registered (multi-cycle datapath), 0 = combinational.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Cond  input  4  instruction condition field, bits [31:28].
REQ-005 ALUFlags  input  4  ALU result flags {N,Z,C,V}, bit 3 = N.
REQ-006 FlagW  input  2  flag-write enables from the ALU decoder; [1] = N/Z group, [0] = C/V group.
REQ-007 PCS, RegW, MemW, NoWrite  input  1 each  raw PC-source, register-write, memory-write, suppress-register-write requests from the main decoder.
REQ-008 stall  input  1  high = hold all state; no flag update.
REQ-009 PCSrc, RegWrite, MemWrite  output  1 each  condition-gated control strobes.
REQ-010 CondEx  output  1  condition-passed indication.
REQ-011 Flags  output  4  current architectural flag register {N,Z,C,V}.

Function
REQ-012 Condition evaluation SHALL use the registered Flags, never ALUFlags of the same cycle.
REQ-013 CondEx SHALL be: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-014 NONE_REG=0: CondEx is combinational from Cond and Flags, zero latency.
REQ-015 NONE_REG=1: CondEx is a register loaded with the evaluated condition each non-stalled cycle; it holds during stall; gated outputs use the registered value (one-cycle latency).
REQ-016 PCSrc = PCS & CondEx; RegWrite = RegW & CondEx & ~NoWrite; MemWrite = MemW & CondEx.
REQ-017 Flags[3:2] SHALL load ALUFlags[3:2] at the clock edge when FlagW[1] & CondEx & ~stall & ~reset.
REQ-018 Flags[1:0] SHALL load ALUFlags[1:0] at the clock edge when FlagW[0] & CondEx & ~stall & ~reset.
REQ-019 Groups are independent; FlagW=10 leaves C,V unchanged; FlagW=00 changes nothing.
REQ-020 Failed condition (CondEx=0) SHALL suppress all three strobes and all flag writes in that cycle.
REQ-021 A flag update and a condition evaluation in the same cycle: evaluation sees old flags, new flags visible from the next cycle.
REQ-022 stall high SHALL not mask the combinational strobes; it blocks state updates only.

Reset
REQ-023 On reset high at a clock edge: Flags <= 0000, registered CondEx <= 0; reset has priority over stall and over any flag write.
REQ-024 After reset, with NONE_REG=0: Cond=1110 gives CondEx=1; Cond=0000 (EQ) gives CondEx=0.
REQ-025 Reset asserted mid-sequence SHALL discard any pending flag write of that cycle.

Structure
REQ-026 Shared package holds: 4-bit condition-code constants (EQ..AL, NV), flag bit indices N=3, Z=2, C=1, V=0, FlagW group indices.
REQ-027 One sub-module, cond_check: purely combinational, inputs Cond and Flags, output CondEx; instantiated once.
REQ-028 Flag register and optional CondEx register reside in cond_logic.

Verification
REQ-029 Reset, then Cond=1110, FlagW=11, ALUFlags=0100 -> next cycle Flags=0100; Cond=0000 then gives CondEx=1.
REQ-030 Flags=0100, Cond=0001 (NE), RegW=1, MemW=1, FlagW=11, ALUFlags=1000 -> RegWrite=0, MemWrite=0, Flags stays 0100.
REQ-031 Flags=0000, Cond=1110, FlagW=10, ALUFlags=1111 -> Flags=1100 next cycle (C,V untouched).
REQ-032 Flags=1001 (N=1,V=1), Cond=1100 (GT), PCS=1 -> PCSrc=1; Flags=1000, Cond=1011 (LT) -> CondEx=1.
REQ-033 stall=1, Cond=1110, FlagW=11, ALUFlags=1111 -> Flags unchanged; reset=1 with same inputs -> Flags=0000.
REQ-034 NONE_REG=1, Cond=1111 then 1110 on successive cycles -> CondEx 0 then 1, each one cycle after its Cond; Cond=1110, RegW=1, NoWrite=1 -> RegWrite=0.
